// File: rtl/demux_stream_n.sv
// Registered 1-to-N stream demultiplexer: one holding register, addressed or
// round-robin destination, back-pressure from the selected consumer only.
module demux_stream_n #(
   parameter int DATA_W = 8,
   parameter int N_CH   = 4,
   parameter int SEL_W  = 2,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mode,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic [SEL_W-1:0]  in_sel,
   output logic              in_ready,
   output logic [N_CH-1:0]   out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic [N_CH-1:0]   out_ready,
   output logic [SEL_W-1:0]  rr_ptr,
   output logic              drop_pulse,
   output logic [CNT_W-1:0]  drop_count
);

   typedef enum logic {S_EMPTY, S_FULL} state_t;

   localparam logic [SEL_W:0]   LP_NCH  = (SEL_W+1)'(N_CH);
   localparam logic [SEL_W-1:0] LP_LAST = SEL_W'(N_CH - 1);

   state_t              r_state, w_state_nxt;
   logic [SEL_W-1:0]    r_dest, r_rr, w_dest;
   logic [DATA_W-1:0]   r_data;
   logic                r_drop;
   logic [CNT_W-1:0]    r_cnt;
   logic                w_dest_ready, w_cap, w_legal, w_load, w_drain;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   function automatic logic [SEL_W-1:0] rr_next(input logic [SEL_W-1:0] p);
      return (p == LP_LAST) ? '0 : p + 1'b1;
   endfunction

   // Only the held beat's own consumer matters; other channels' ready is ignored.
   always_comb begin
      w_dest_ready = 1'b0;
      for (int i = 0; i < N_CH; i++)
         if (r_dest == SEL_W'(i)) w_dest_ready = out_ready[i];
   end

   assign w_dest   = mode ? r_rr : in_sel;
   assign w_legal  = ({1'b0, w_dest} < LP_NCH);
   assign in_ready = !rst && ((r_state == S_EMPTY) || w_dest_ready);
   assign w_cap    = in_valid && in_ready;
   assign w_load   = w_cap && w_legal;
   assign w_drain  = (r_state == S_FULL) && w_dest_ready;

   always_comb begin
      w_state_nxt = r_state;
      if (w_load)       w_state_nxt = S_FULL;
      else if (w_drain) w_state_nxt = S_EMPTY;
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_EMPTY;
      else     r_state <= w_state_nxt;
   end

   // Illegal-select beats are consumed here but never loaded into the holding register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_data <= '0;
         r_dest <= '0;
         r_rr   <= '0;
         r_drop <= 1'b0;
         r_cnt  <= '0;
      end else begin
         r_drop <= w_cap && !w_legal;
         if (w_cap && !w_legal) r_cnt <= sat_inc(r_cnt);
         if (w_cap && mode)     r_rr  <= rr_next(r_rr);
         if (w_load) begin
            r_data <= in_data;
            r_dest <= w_dest;
         end
      end
   end

   always_comb begin
      out_valid = '0;
      for (int i = 0; i < N_CH; i++)
         out_valid[i] = (r_state == S_FULL) && (r_dest == SEL_W'(i));
   end

   assign out_data   = r_data;
   assign rr_ptr     = r_rr;
   assign drop_pulse = r_drop;
   assign drop_count = r_cnt;

endmodule

// File: tb/tb_demux_stream_n.sv
// Bench for demux_stream_n: a 4-channel and a 3-channel/2-bit-counter instance
// share stimulus; a per-cycle model check plus directed literal checks.
module tb_demux_stream_n;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       mode = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = '0;
   logic [1:0] in_sel = '0;
   logic [3:0] out_ready = 4'hF;

   logic       ir0, ir1, dp0, dp1;
   logic [3:0] ov0;
   logic [2:0] ov1;
   logic [7:0] od0, od1, dc0;
   logic [1:0] rr0, rr1, dc1;

   int n_vec  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   demux_stream_n #(.DATA_W(8), .N_CH(4), .SEL_W(2), .CNT_W(8)) dut0 (
      .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_data(in_data),
      .in_sel(in_sel), .in_ready(ir0), .out_valid(ov0), .out_data(od0),
      .out_ready(out_ready), .rr_ptr(rr0), .drop_pulse(dp0), .drop_count(dc0));

   demux_stream_n #(.DATA_W(8), .N_CH(3), .SEL_W(2), .CNT_W(2)) dut1 (
      .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_data(in_data),
      .in_sel(in_sel), .in_ready(ir1), .out_valid(ov1), .out_data(od1),
      .out_ready(out_ready[2:0]), .rr_ptr(rr1), .drop_pulse(dp1), .drop_count(dc1));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: one optional held beat per instance, plus pointer and counters.
   int nch[2]    = '{4, 3};
   int cmax[2]   = '{255, 3};
   bit m_held[2] = '{0, 0};
   int m_dest[2] = '{0, 0};
   int m_data[2] = '{0, 0};
   int m_rr[2]   = '{0, 0};
   bit m_dp[2]   = '{0, 0};
   int m_cnt[2]  = '{0, 0};

   always @(negedge clk) begin
      logic [31:0] a_ov, a_od, a_rr, a_dp, a_dc, a_ir;
      int  d;
      bit  rdy, cap, drn;
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            a_ov = (i == 0) ? 32'(ov0) : 32'(ov1);
            a_od = (i == 0) ? 32'(od0) : 32'(od1);
            a_rr = (i == 0) ? 32'(rr0) : 32'(rr1);
            a_dp = (i == 0) ? 32'(dp0) : 32'(dp1);
            a_dc = (i == 0) ? 32'(dc0) : 32'(dc1);
            a_ir = (i == 0) ? 32'(ir0) : 32'(ir1);
            chk($sformatf("m%0d out_valid", i), a_ov, m_held[i] ? (32'd1 << m_dest[i]) : 32'd0);
            chk($sformatf("m%0d out_data", i), a_od, 32'(m_data[i]));
            chk($sformatf("m%0d rr_ptr", i), a_rr, 32'(m_rr[i]));
            chk($sformatf("m%0d drop_pulse", i), a_dp, 32'(m_dp[i]));
            chk($sformatf("m%0d drop_count", i), a_dc, 32'(m_cnt[i]));
            chk($sformatf("m%0d in_ready", i), a_ir,
                32'(!rst && (!m_held[i] || out_ready[m_dest[i]])));
         end
      end
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            m_held[i] = 0; m_data[i] = 0; m_rr[i] = 0; m_dp[i] = 0; m_cnt[i] = 0;
         end else begin
            rdy = !m_held[i] || out_ready[m_dest[i]];
            cap = in_valid && rdy;
            drn = m_held[i] && out_ready[m_dest[i]];
            d   = mode ? m_rr[i] : int'(in_sel);
            m_dp[i] = cap && (d >= nch[i]);
            if (m_dp[i] && m_cnt[i] < cmax[i]) m_cnt[i]++;
            if (cap && mode) m_rr[i] = (m_rr[i] + 1) % nch[i];
            if (cap && d < nch[i]) begin
               m_held[i] = 1; m_dest[i] = d; m_data[i] = int'(in_data);
            end else if (drn) begin
               m_held[i] = 0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] t1_data[4] = '{8'h11, 8'h22, 8'h33, 8'h44};

   initial begin
      // Reset state
      tick();
      chk_en = 1'b1;
      chk("rst out_valid", 32'(ov0), 'h0);
      chk("rst out_data", 32'(od0), 'h0);
      chk("rst in_ready", 32'(ir0), 'h0);
      rst = 1'b0;
      #1 chk("post-rst in_ready", 32'(ir0), 'h1);

      // Addressed back-to-back, all ready
      in_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         in_sel = 2'(k); in_data = t1_data[k];
         tick();
         #1;
         chk("t1 out_valid", 32'(ov0), 32'd1 << k);
         chk("t1 out_data", 32'(od0), 32'(t1_data[k]));
      end
      in_valid = 1'b0;
      tick();
      #1 chk("t1 drained", 32'(ov0), 'h0);

      // Stall on channel 2
      in_valid = 1'b1; in_sel = 2'd2; in_data = 8'hA5; out_ready = 4'b1011;
      tick();
      in_valid = 1'b0;
      repeat (5) begin
         #1;
         chk("t2 out_valid", 32'(ov0), 'h4);
         chk("t2 out_data", 32'(od0), 'hA5);
         chk("t2 in_ready", 32'(ir0), 'h0);
         tick();
      end
      out_ready = 4'hF;
      #1 chk("t2 release in_ready", 32'(ir0), 'h1);
      tick();
      #1 chk("t2 drained", 32'(ov0), 'h0);

      // Round-robin, 6 beats
      rst = 1'b1; tick(); rst = 1'b0;
      mode = 1'b1; in_valid = 1'b1;
      for (int k = 0; k < 6; k++) begin
         in_data = 8'(k + 1);
         tick();
         #1;
         chk("t3 out_valid n4", 32'(ov0), 32'd1 << (k % 4));
         chk("t3 out_valid n3", 32'(ov1), 32'd1 << (k % 3));
      end
      in_valid = 1'b0;
      chk("t3 rr_ptr n4", 32'(rr0), 'h2);
      chk("t3 rr_ptr n3", 32'(rr1), 'h0);
      tick();

      // Illegal select on the 3-channel instance, counter saturation
      mode = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
      in_valid = 1'b1; in_sel = 2'd3; in_data = 8'h7E;
      tick();
      in_valid = 1'b0;
      #1;
      chk("t4 out_valid", 32'(ov1), 'h0);
      chk("t4 drop_pulse", 32'(dp1), 'h1);
      chk("t4 drop_count", 32'(dc1), 'h1);
      tick();
      #1 chk("t4 pulse ends", 32'(dp1), 'h0);
      in_valid = 1'b1;
      repeat (4) tick();
      in_valid = 1'b0;
      #1 chk("t4 saturate", 32'(dc1), 'h3);
      tick();

      // Reset while FULL on channel 1
      mode = 1'b1; in_valid = 1'b1; in_data = 8'h5A;
      tick();
      mode = 1'b0; in_sel = 2'd1; in_data = 8'h96;
      tick();
      in_valid = 1'b0; out_ready = 4'h0;
      #1;
      chk("t5 out_valid", 32'(ov0), 'h2);
      chk("t5 rr_ptr", 32'(rr0), 'h1);
      chk("t5 drop_count", 32'(dc1), 'h3);
      rst = 1'b1;
      #1 chk("t5 in_ready in rst", 32'(ir0), 'h0);
      tick();
      rst = 1'b0;
      #1;
      chk("t5 out_valid", 32'(ov0), 'h0);
      chk("t5 rr_ptr", 32'(rr0), 'h0);
      chk("t5 drop_count", 32'(dc1), 'h0);
      chk("t5 in_ready", 32'(ir0), 'h1);

      // Mode flip while stalled on channel 3
      out_ready = 4'b0111; in_sel = 2'd3; in_data = 8'hC3; in_valid = 1'b1;
      tick();
      in_valid = 1'b0; mode = 1'b1;
      tick(); tick();
      #1;
      chk("t6 held out_valid", 32'(ov0), 'h8);
      chk("t6 held out_data", 32'(od0), 'hC3);
      out_ready = 4'hF; in_valid = 1'b1; in_data = 8'h3C;
      #1 chk("t6 in_ready", 32'(ir0), 'h1);
      tick();
      in_valid = 1'b0;
      #1;
      chk("t6 rr out_valid", 32'(ov0), 'h1);
      chk("t6 rr out_data", 32'(od0), 'h3C);
      chk("t6 rr_ptr", 32'(rr0), 'h1);
      tick();

      // Randomised traffic
      repeat (3000) begin
         rst       = ($urandom_range(0, 63) == 0);
         if ($urandom_range(0, 15) == 0) mode = ~mode;
         in_valid  = ($urandom_range(0, 3) != 0);
         in_sel    = 2'($urandom);
         in_data   = 8'($urandom);
         out_ready = 4'($urandom) | 4'($urandom);
         tick();
      end
      rst = 1'b0; in_valid = 1'b0; out_ready = 4'hF;
      tick(); tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
